// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the seven-segment scan driver:
//               segment word type, blank pattern and the hex glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low segment word: bit0=a .. bit6=g, bit7=dp
  typedef logic [7:0] seg_t;

  // Every segment and the decimal point dark
  localparam seg_t SEG_BLANK = 8'hFF;

  // g..a all dark, used for suppressed leading zeros
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low g..a glyphs for hex digits 0..F (b and d lower case)
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decode
// Description : Combinational nibble + decimal point to active-low segment
//               pattern; blank_i darkens g..a but leaves the dp under control.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Glyph lookup with optional blanking; dp is inverted for the common anode
  always_comb begin
    seg_o      = SEG_BLANK;
    seg_o[6:0] = blank_i ? SEG_OFF : HEX_PAT[nib_i];
    seg_o[7]   = ~dp_i;
  end

endmodule : seg_hex_decode
`default_nettype wire

// File: rtl/seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan
// Description : Multiplexed N-digit common-anode seven-segment driver with a
//               double-buffered frame, full hex decode, per-digit dp,
//               leading-zero suppression and anode dead-time.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan
  import seg_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Pending (written by load) and shadow (displayed) frame buffers
  logic                pend_q, pend_d;
  logic [4*DIGITS-1:0] pval_q, pval_d;
  logic [DIGITS-1:0]   pdp_q,  pdp_d;
  logic                plz_q,  plz_d;
  logic [4*DIGITS-1:0] sval_q, sval_d;
  logic [DIGITS-1:0]   sdp_q,  sdp_d;
  logic                slz_q,  slz_d;

  // Registered pin drivers
  logic [7:0]          seg_q;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q;

  logic                cnt_tc;
  logic                boundary;
  logic [3:0]          nib_w [DIGITS];
  logic [DIGITS-1:0]   blank_w;
  logic [7:0]          seg_d;

  // Slot prescaler and digit index; a frame ends on the last slot's wrap
  always_comb begin
    cnt_tc   = (cnt_q == CNT_LAST);
    boundary = cnt_tc && (idx_q == IDX_LAST);
    cnt_d    = cnt_tc ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (cnt_tc) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Double buffer: loads park in pending, move to shadow at a frame boundary;
  // a load landing exactly on the boundary goes straight to the shadow
  always_comb begin
    pend_d = pend_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    plz_d  = plz_q;
    sval_d = sval_q;
    sdp_d  = sdp_q;
    slz_d  = slz_q;
    if (load && boundary) begin
      sval_d = value;
      sdp_d  = dp_in;
      slz_d  = lz_en;
      pend_d = 1'b0;
    end else begin
      if (boundary && pend_q) begin
        sval_d = pval_q;
        sdp_d  = pdp_q;
        slz_d  = plz_q;
        pend_d = 1'b0;
      end
      if (load) begin
        pval_d = value;
        pdp_d  = dp_in;
        plz_d  = lz_en;
        pend_d = 1'b1;
      end
    end
  end

  // Split the shadow into nibbles and work out which digits are leading zeros
  generate
    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      assign nib_w[k] = sval_q[4*k +: 4];
      if (k == 0) begin : g_lsd
        assign blank_w[k] = 1'b0;
      end else begin : g_upper
        assign blank_w[k] = slz_q & ~|sval_q[4*DIGITS-1:4*k];
      end
    end
  endgenerate

  seg_hex_decode u_decode (
    .nib_i   (nib_w[idx_q]),
    .dp_i    (sdp_q[idx_q]),
    .blank_i (blank_w[idx_q]),
    .seg_o   (seg_d)
  );

  // Anodes stay dark for the first BLANK_CYCLES of each slot to avoid ghosting
  always_comb begin
    an_d = '1;
    if (cnt_q >= BLANK_LIM) begin
      an_d[idx_q] = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      pend_q <= 1'b0;
      pval_q <= '0;
      pdp_q  <= '0;
      plz_q  <= 1'b0;
      sval_q <= '0;
      sdp_q  <= '0;
      slz_q  <= 1'b0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
      fd_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pend_q <= pend_d;
      pval_q <= pval_d;
      pdp_q  <= pdp_d;
      plz_q  <= plz_d;
      sval_q <= sval_d;
      sdp_q  <= sdp_d;
      slz_q  <= slz_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      fd_q   <= boundary;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule : seven_segment_scan
`default_nettype wire

// File: tb/tb_seven_segment_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scan
// Description : Directed, table-driven bench for seven_segment_scan with
//               DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1 (16-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        lz_en;
  logic        load;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp_seg;   // digit k expected at [8k+7:8k]
  } vec_t;

  vec_t       vecs [7];
  logic [6:0] pat  [16];

  seven_segment_scan #(
    .DIGITS       (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .lz_en      (lz_en),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic lz);
    value = v;
    dp_in = dp;
    lz_en = lz;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Advance until frame_done is seen; afterwards the scan sits at slot 0, cnt 0
  task automatic wait_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL wait_frame: frame_done got 0 expected 1 within 40 cycles");
    end
  endtask

  // Called right after wait_frame: samples the lit cycle of every digit slot
  task automatic check_frame(input logic [31:0] exp, input string tag);
    logic [3:0] ea;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) repeat (4) tick();
      ea = ~(4'b0001 << k);
      chk($sformatf("%s_seg%0d", tag, k), {24'h0, seg}, {24'h0, exp[8*k +: 8]});
      chk($sformatf("%s_an%0d", tag, k), {28'h0, an}, {28'h0, ea});
    end
  endtask

  initial begin
    vecs[0] = '{value: 16'hA5C3, dp: 4'b0100, lz: 1'b0, exp_seg: 32'h8812C6B0};
    vecs[1] = '{value: 16'h0070, dp: 4'b0000, lz: 1'b1, exp_seg: 32'hFFFFF8C0};
    vecs[2] = '{value: 16'h0000, dp: 4'b0000, lz: 1'b1, exp_seg: 32'hFFFFFFC0};
    vecs[3] = '{value: 16'h0000, dp: 4'b1010, lz: 1'b1, exp_seg: 32'h7FFF7FC0};
    vecs[4] = '{value: 16'h1234, dp: 4'b0001, lz: 1'b0, exp_seg: 32'hF9A4B019};
    vecs[5] = '{value: 16'h0B0D, dp: 4'b0000, lz: 1'b1, exp_seg: 32'hFF83C0A1};
    vecs[6] = '{value: 16'h8E6F, dp: 4'b1111, lz: 1'b0, exp_seg: 32'h0006020E};

    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    rst_n = 1'b0;
    value = '0;
    dp_in = '0;
    lz_en = 1'b0;
    load  = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    chk("rst_an",  {28'h0, an},  32'hF);
    chk("rst_fd",  {31'h0, frame_done}, 32'h0);

    // Release: outputs hold reset values until the first edge, then scan zeros
    rst_n = 1'b1;
    chk("rel_seg", {24'h0, seg}, 32'hFF);
    chk("rel_an",  {28'h0, an},  32'hF);
    for (int k = 1; k <= 17; k++) begin
      tick();
      case (k)
        1:  chk("start_an1",  {28'h0, an}, 32'hF);
        2:  begin
              chk("start_an2",  {28'h0, an}, 32'hE);
              chk("start_seg2", {24'h0, seg}, 32'hC0);
            end
        5:  chk("start_an5",  {28'h0, an}, 32'hF);
        6:  chk("start_an6",  {28'h0, an}, 32'hD);
        10: chk("start_an10", {28'h0, an}, 32'hB);
        14: chk("start_an14", {28'h0, an}, 32'h7);
        15: chk("start_fd15", {31'h0, frame_done}, 32'h0);
        16: chk("start_fd16", {31'h0, frame_done}, 32'h1);
        17: chk("start_fd17", {31'h0, frame_done}, 32'h0);
        default: ;
      endcase
    end

    // Mid-frame load: old display (zeros) holds for the rest of this frame
    wait_frame();
    tick();
    tick();
    do_load(vecs[0].value, vecs[0].dp, vecs[0].lz);
    repeat (3) tick();
    chk("hold_seg1", {24'h0, seg}, 32'hC0);
    chk("hold_an1",  {28'h0, an},  32'hD);

    // Table of display vectors
    for (int i = 0; i < 7; i++) begin
      if (i > 0) do_load(vecs[i].value, vecs[i].dp, vecs[i].lz);
      wait_frame();
      check_frame(vecs[i].exp_seg, $sformatf("vec%0d", i));
    end

    // All sixteen glyphs through digit 0, dp lit on odd codes
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nib;
      logic       dp0;
      nib = 4'(n);
      dp0 = nib[0];
      do_load({12'h000, nib}, {3'b000, dp0}, 1'b0);
      wait_frame();
      tick();
      tick();
      chk($sformatf("hex%0d", n), {24'h0, seg}, {24'h0, ~dp0, pat[n]});
    end

    // Two loads in one frame: the later one wins
    wait_frame();
    repeat (3) tick();
    do_load(16'h1111, 4'b0000, 1'b0);
    tick();
    do_load(16'h2222, 4'b0000, 1'b0);
    wait_frame();
    check_frame(32'hA4A4A4A4, "b2b");

    // Load on the boundary cycle reaches the very next lit slot
    wait_frame();
    repeat (15) tick();
    do_load(16'h3333, 4'b0000, 1'b0);
    chk("bnd_fd",  {31'h0, frame_done}, 32'h1);
    tick();
    chk("bnd_an0", {28'h0, an}, 32'hF);
    tick();
    chk("bnd_an1", {28'h0, an}, 32'hE);
    chk("bnd_seg", {24'h0, seg}, 32'hB0);

    // Mid-frame reset with pending data and a simultaneous load: all discarded
    tick();
    do_load(16'h4444, 4'b1111, 1'b0);
    tick();
    rst_n = 1'b0;
    value = 16'h5555;
    load  = 1'b1;
    tick();
    chk("mrst_seg", {24'h0, seg}, 32'hFF);
    chk("mrst_an",  {28'h0, an},  32'hF);
    chk("mrst_fd",  {31'h0, frame_done}, 32'h0);
    rst_n = 1'b1;
    load  = 1'b0;
    wait_frame();
    check_frame(32'hC0C0C0C0, "mrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_seven_segment_scan
`default_nettype wire

// File: doc/seven_segment_scan.md
# seven_segment_scan

Multiplexed N-digit seven-segment display driver for the lab board's common-anode display. It holds a frame-buffered hex value, scans one digit per refresh slot, and decodes all sixteen hex codes (0–F), not just BCD. It also adds per-digit decimal points, optional leading-zero suppression and an anode dead-time against ghosting. It sits between any counter or datapath producing a binary value and the board's `seg`/`an` pins.

## Interface
- `DIGITS`, 4: number of digits scanned; legal 1..8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot; legal ≥2 (100 MHz → 2 kHz per digit).
- `BLANK_CYCLES`, 500: cycles at the start of each slot with all anodes off; legal 0..REFRESH_DIV-1.

- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  synchronous, active-low reset.
- `value`  in  4*DIGITS  hex nibbles; nibble k = `value[4k+3:4k]` drives digit k; digit 0 is least significant.
- `dp_in`  in  DIGITS  decimal point per digit, 1 = lit.
- `lz_en`  in  1  leading-zero suppression enable.
- `load`  in  1  one-cycle strobe; captures `value`, `dp_in` and `lz_en`.
- `seg`  out  8  active-low segments: bit0=a … bit6=g, bit7=dp.
- `an`  out  DIGITS  active-low anode enables, one-hot-low while a digit is on.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Prescaler `cnt` runs 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and advances the digit index `idx` (0..DIGITS-1, wrapping).
- Frame boundary: the terminal count occurs with `idx`=DIGITS-1.
- Double buffer:
  - `load` copies the inputs into the pending register and sets `pend`.
  - At a frame boundary with `pend`=1, pending is copied to the display shadow and `pend` clears.
  - `load` on a boundary cycle bypasses pending: the inputs go straight to the shadow and `pend` clears.
  - Back-to-back loads: the last one before the boundary wins.
- Decode uses the shadow only. Active-low g..a patterns:
  - 0–7: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8–F: 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - dp bit = ~dp of the current digit.
- Leading-zero suppression, when the shadow `lz_en`=1:
  - A digit k>0 is blanked (g..a = 7F) if it and every higher nibble are 0.
  - Digit 0 is never blanked.
  - The dp of a blanked digit still follows `dp_in`.
- Dead-time: while `cnt` < BLANK_CYCLES, `an` is all ones. Otherwise `an[idx]`=0 and all other bits are 1.

## Timing
- Reset values (synchronous, applied on the `clk` edge with `rst_n`=0):
  - `seg`=8'hFF, `an`=all ones, `frame_done`=0.
  - `cnt`=0, `idx`=0, shadow=0, pending=0, `pend`=0.
- Reset overrides `load` in the same cycle and aborts any frame in progress; no partial update survives.
- `seg`, `an` and `frame_done` are registered, one cycle after the `cnt`/`idx` state that produces them.
- First lit anode after reset release: cycle BLANK_CYCLES+1.
- `frame_done` is high for exactly one cycle, the cycle after the frame-boundary state.
- Load-to-display latency: at most DIGITS*REFRESH_DIV+1 cycles; exactly 1 cycle for a boundary-cycle load.
- Widths: `cnt` is $clog2(REFRESH_DIV) bits; `idx` is max(1,$clog2(DIGITS)) bits. Both compare against terminal constants and never overflow.
- DIGITS=1: `idx` stays 0; every slot wrap is a frame boundary.

## Structure
- Package `seg_pkg`:
  - `SEG_BLANK`=8'hFF.
  - The 16-entry hex pattern constant array.
  - A `seg_t` 8-bit typedef.
- Sub-module `seg_hex_decode`: combinational nibble + dp → active-low 8-bit pattern, with a blank input. One instance, fed by the shadow nibble selected by `idx`.
- Top module holds the prescaler, digit counter, double buffer, suppression logic and output registers.

## Test plan
Bench parameters: DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset, then release → `seg`=FF and `an`=F for the first cycle. Shadow=0, so lit slots show `seg`=C0 (digit "0") with `an` cycling E,D,B,7 every 4 cycles; each slot's first cycle has `an`=F. `frame_done` pulses every 16 cycles.
- `load` with `value`=16'hA5C3, `dp_in`=4'b0100, `lz_en`=0, mid-frame → old display holds until the boundary. Then per digit (0..3): 0=B0, 1=C6, 2=12 (dp lit), 3=88.
- `load` with `value`=16'h0070, `lz_en`=1 → digits 3 and 2 show FF, digit 1 shows F8 ("7"), digit 0 shows C0. With `value`=0, digit 0 still shows C0.
- Two loads in one frame (1111, then 2222) → only 2222 is displayed after the boundary. A load on the boundary cycle appears on the next lit slot.
- Assert `rst_n`=0 for one cycle mid-frame with `pend`=1 → next cycle `seg`=FF, `an`=F, and the pending data is discarded.
- All 16 nibbles scanned through digit 0 → each `seg` matches the package table, with dp=1 when its `dp_in` bit is 0.
